rx_serial_fifo: RTL and testbench

//   Receive buffer directly downstream of the UART RX datapath/FSM. Captures each received

---
 rtl/rx_serial_fifo.sv | 115 +++++++++++
 tb/tb_rx_serial_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rx_serial_fifo.sv
// rx_serial_fifo: receive buffer behind the UART RX datapath.
// Stores {parity_ok, data} per received word in a first-word-fall-through FIFO,
// with sticky overrun and parity-error flags so slow consumers never lose frames silently.
module rx_serial_fifo #(
    parameter int N_BITS          = 8,
    parameter int DEPTH           = 8,
    parameter int DROP_PARITY_ERR = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       zera,
    input  logic                       wr_en,
    input  logic [N_BITS-1:0]          wr_data,
    input  logic                       wr_parity_ok,
    input  logic                       rd_en,
    output logic [N_BITS-1:0]          rd_data,
    output logic                       rd_parity_ok,
    output logic                       vazio,
    output logic                       cheio,
    output logic [$clog2(DEPTH):0]     contagem,
    output logic                       overrun,
    output logic                       erro_paridade
);

    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;
    localparam bit DropEn = (DROP_PARITY_ERR != 0);

    logic [N_BITS:0]   mem_q [DEPTH];
    logic [PW-1:0]     wrPtr_q, wrPtr_d;
    logic [PW-1:0]     rdPtr_q, rdPtr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overrun_q, overrun_d;
    logic              parErr_q, parErr_d;

    logic              pop;
    logic              keep;
    logic              push;

    assign vazio = (count_q == '0);
    assign cheio = (count_q == CW'(DEPTH));

    // A pop only happens when there is something to pop; a push needs room, or a slot
    // freed by a same-cycle pop. Bad-parity words may be filtered out before storage.
    always_comb begin
        pop  = rd_en & ~vazio;
        keep = ~(DropEn & ~wr_parity_ok);
        push = wr_en & keep & (~cheio | pop);
    end

    // Next-state for pointers, occupancy and sticky flags; the sync clear overrides everything.
    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        parErr_d  = parErr_q;
        if (zera) begin
            wrPtr_d   = '0;
            rdPtr_d   = '0;
            count_d   = '0;
            overrun_d = 1'b0;
            parErr_d  = 1'b0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (wr_en & keep & cheio & ~pop) begin
                overrun_d = 1'b1;
            end
            if (wr_en & ~wr_parity_ok) begin
                parErr_d = 1'b1;
            end
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            parErr_q  <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            parErr_q  <= parErr_d;
        end
    end

    // Storage array; contents survive clears, only the pointers are reset.
    always_ff @(posedge clock) begin
        if (push && !zera) begin
            mem_q[wrPtr_q] <= {wr_parity_ok, wr_data};
        end
    end

    assign rd_data       = mem_q[rdPtr_q][N_BITS-1:0];
    assign rd_parity_ok  = mem_q[rdPtr_q][N_BITS];
    assign contagem      = count_q;
    assign overrun       = overrun_q;
    assign erro_paridade = parErr_q;

endmodule

// File: tb/tb_rx_serial_fifo.sv
// Directed testbench for rx_serial_fifo; a second instance exercises parity-drop mode.
module tb_rx_serial_fifo;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       zera = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_parity_ok = 1'b1;
    logic       rd_en = 1'b0;

    logic [7:0] rd_data, rd_data_drop;
    logic       rd_parity_ok, rd_parity_ok_drop;
    logic       vazio, vazio_drop;
    logic       cheio, cheio_drop;
    logic [3:0] contagem, contagem_drop;
    logic       overrun, overrun_drop;
    logic       erro_paridade, erro_paridade_drop;

    int checkCount = 0;
    int passCount  = 0;

    rx_serial_fifo #(.N_BITS(8), .DEPTH(8), .DROP_PARITY_ERR(0)) dut (
        .clock(clock), .reset(reset), .zera(zera),
        .wr_en(wr_en), .wr_data(wr_data), .wr_parity_ok(wr_parity_ok),
        .rd_en(rd_en), .rd_data(rd_data), .rd_parity_ok(rd_parity_ok),
        .vazio(vazio), .cheio(cheio), .contagem(contagem),
        .overrun(overrun), .erro_paridade(erro_paridade)
    );

    rx_serial_fifo #(.N_BITS(8), .DEPTH(8), .DROP_PARITY_ERR(1)) dutDrop (
        .clock(clock), .reset(reset), .zera(zera),
        .wr_en(wr_en), .wr_data(wr_data), .wr_parity_ok(wr_parity_ok),
        .rd_en(rd_en), .rd_data(rd_data_drop), .rd_parity_ok(rd_parity_ok_drop),
        .vazio(vazio_drop), .cheio(cheio_drop), .contagem(contagem_drop),
        .overrun(overrun_drop), .erro_paridade(erro_paridade_drop)
    );

    // Free-running 10-unit clock.
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyPush(input logic [7:0] d, input logic p);
        wr_en = 1'b1; wr_data = d; wr_parity_ok = p;
        tick();
        wr_en = 1'b0; wr_parity_ok = 1'b1;
    endtask

    task automatic applyPop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic applyZera();
        zera = 1'b1;
        tick();
        zera = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        checkCount++; if (vazio !== 1'b1) $display("[TB] FAIL reset_vazio: got %b expected 1", vazio); else passCount++;
        checkCount++; if (cheio !== 1'b0) $display("[TB] FAIL reset_cheio: got %b expected 0", cheio); else passCount++;
        checkCount++; if (contagem !== 4'd0) $display("[TB] FAIL reset_contagem: got %0d expected 0", contagem); else passCount++;
        checkCount++; if (overrun !== 1'b0) $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); else passCount++;
        checkCount++; if (erro_paridade !== 1'b0) $display("[TB] FAIL reset_erro: got %b expected 0", erro_paridade); else passCount++;
    endtask

    task automatic test_basic();
        applyPush(8'hA5, 1'b1);
        checkCount++; if (vazio !== 1'b0) $display("[TB] FAIL basic_vazio: got %b expected 0", vazio); else passCount++;
        checkCount++; if (contagem !== 4'd1) $display("[TB] FAIL basic_contagem: got %0d expected 1", contagem); else passCount++;
        checkCount++; if (rd_data !== 8'hA5) $display("[TB] FAIL basic_rd_data: got %h expected a5", rd_data); else passCount++;
        checkCount++; if (rd_parity_ok !== 1'b1) $display("[TB] FAIL basic_parity: got %b expected 1", rd_parity_ok); else passCount++;
        applyPop();
        checkCount++; if (vazio !== 1'b1) $display("[TB] FAIL basic_pop_vazio: got %b expected 1", vazio); else passCount++;
        checkCount++; if (contagem !== 4'd0) $display("[TB] FAIL basic_pop_contagem: got %0d expected 0", contagem); else passCount++;
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 8; i++) applyPush(8'(i), 1'b1);
        checkCount++; if (cheio !== 1'b1) $display("[TB] FAIL ovr_cheio: got %b expected 1", cheio); else passCount++;
        checkCount++; if (overrun !== 1'b0) $display("[TB] FAIL ovr_pre_flag: got %b expected 0", overrun); else passCount++;
        applyPush(8'h09, 1'b1);
        checkCount++; if (overrun !== 1'b1) $display("[TB] FAIL ovr_flag: got %b expected 1", overrun); else passCount++;
        checkCount++; if (contagem !== 4'd8) $display("[TB] FAIL ovr_contagem: got %0d expected 8", contagem); else passCount++;
        for (int i = 1; i <= 8; i++) begin
            checkCount++; if (rd_data !== 8'(i)) $display("[TB] FAIL ovr_order%0d: got %h expected %h", i, rd_data, 8'(i)); else passCount++;
            applyPop();
        end
        checkCount++; if (vazio !== 1'b1) $display("[TB] FAIL ovr_drained: got %b expected 1", vazio); else passCount++;
        checkCount++; if (overrun !== 1'b1) $display("[TB] FAIL ovr_sticky: got %b expected 1", overrun); else passCount++;
        applyZera();
        checkCount++; if (overrun !== 1'b0) $display("[TB] FAIL ovr_zera: got %b expected 0", overrun); else passCount++;
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) applyPush(8'(8'h10 + i), 1'b1);
        wr_en = 1'b1; wr_data = 8'h55; wr_parity_ok = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checkCount++; if (contagem !== 4'd8) $display("[TB] FAIL b2b_contagem: got %0d expected 8", contagem); else passCount++;
        checkCount++; if (overrun !== 1'b0) $display("[TB] FAIL b2b_overrun: got %b expected 0", overrun); else passCount++;
        for (int i = 2; i <= 9; i++) begin
            logic [7:0] exp;
            exp = (i == 9) ? 8'h55 : 8'(8'h10 + i);
            checkCount++; if (rd_data !== exp) $display("[TB] FAIL b2b_order%0d: got %h expected %h", i, rd_data, exp); else passCount++;
            applyPop();
        end
        wr_en = 1'b1; wr_data = 8'h66; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checkCount++; if (contagem !== 4'd1) $display("[TB] FAIL b2b_empty_contagem: got %0d expected 1", contagem); else passCount++;
        checkCount++; if (rd_data !== 8'h66) $display("[TB] FAIL b2b_empty_data: got %h expected 66", rd_data); else passCount++;
        applyPop();
    endtask

    task automatic test_parity();
        applyZera();
        applyPush(8'h3C, 1'b0);
        checkCount++; if (contagem !== 4'd1) $display("[TB] FAIL par_contagem: got %0d expected 1", contagem); else passCount++;
        checkCount++; if (rd_data !== 8'h3C) $display("[TB] FAIL par_data: got %h expected 3c", rd_data); else passCount++;
        checkCount++; if (rd_parity_ok !== 1'b0) $display("[TB] FAIL par_flag: got %b expected 0", rd_parity_ok); else passCount++;
        checkCount++; if (erro_paridade !== 1'b1) $display("[TB] FAIL par_erro: got %b expected 1", erro_paridade); else passCount++;
        checkCount++; if (contagem_drop !== 4'd0) $display("[TB] FAIL pardrop_contagem: got %0d expected 0", contagem_drop); else passCount++;
        checkCount++; if (vazio_drop !== 1'b1) $display("[TB] FAIL pardrop_vazio: got %b expected 1", vazio_drop); else passCount++;
        checkCount++; if (erro_paridade_drop !== 1'b1) $display("[TB] FAIL pardrop_erro: got %b expected 1", erro_paridade_drop); else passCount++;
        applyZera();
    endtask

    task automatic test_wrap();
        logic [7:0] expQ[$];
        logic [7:0] nextByte;
        logic [7:0] exp;
        nextByte = 8'h40;
        for (int i = 0; i < 3; i++) begin
            applyPush(nextByte, 1'b1); expQ.push_back(nextByte); nextByte++;
        end
        for (int i = 0; i < 20; i++) begin
            applyPush(nextByte, 1'b1); expQ.push_back(nextByte); nextByte++;
            checkCount++; if (contagem > 4'd8 || contagem !== 4'(expQ.size())) $display("[TB] FAIL wrap_count%0d: got %0d expected %0d", i, contagem, expQ.size()); else passCount++;
            exp = expQ.pop_front();
            checkCount++; if (rd_data !== exp) $display("[TB] FAIL wrap_data%0d: got %h expected %h", i, rd_data, exp); else passCount++;
            applyPop();
        end
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            checkCount++; if (rd_data !== exp) $display("[TB] FAIL wrap_drain: got %h expected %h", rd_data, exp); else passCount++;
            applyPop();
        end
        applyPop();
        checkCount++; if (contagem !== 4'd0) $display("[TB] FAIL underflow_contagem: got %0d expected 0", contagem); else passCount++;
        checkCount++; if (vazio !== 1'b1 || overrun !== 1'b0) $display("[TB] FAIL underflow_flags: got vazio=%b overrun=%b expected 1/0", vazio, overrun); else passCount++;
    endtask

    task automatic test_async_reset();
        applyPush(8'h81, 1'b1);
        applyPush(8'h82, 1'b0);
        applyPush(8'h83, 1'b1);
        checkCount++; if (contagem !== 4'd3 || erro_paridade !== 1'b1) $display("[TB] FAIL ares_pre: got cnt=%0d erro=%b expected 3/1", contagem, erro_paridade); else passCount++;
        #3 reset = 1'b1;
        #1;
        checkCount++; if (contagem !== 4'd0) $display("[TB] FAIL ares_contagem: got %0d expected 0", contagem); else passCount++;
        checkCount++; if (vazio !== 1'b1) $display("[TB] FAIL ares_vazio: got %b expected 1", vazio); else passCount++;
        checkCount++; if (erro_paridade !== 1'b0 || overrun !== 1'b0) $display("[TB] FAIL ares_flags: got erro=%b ovr=%b expected 0/0", erro_paridade, overrun); else passCount++;
        #1 reset = 1'b0;
        tick();
        applyPush(8'h77, 1'b1);
        checkCount++; if (contagem !== 4'd1) $display("[TB] FAIL ares_push_cnt: got %0d expected 1", contagem); else passCount++;
        checkCount++; if (rd_data !== 8'h77) $display("[TB] FAIL ares_push_data: got %h expected 77", rd_data); else passCount++;
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_back_to_back();
        test_parity();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
